// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: single-outstanding imem requests, 2-entry {pc, instr} queue to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        grant, push, pop;
  logic        unused_pc_lsbs;

  // Redirect targets are forced word-aligned; the low bits carry no meaning here.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    imem_req  = (state == S_IDLE) && (count < 2'd2) && !redirect && !reset;
    imem_addr = fetch_pc;
    grant     = imem_req && imem_gnt;
    push      = (state == S_WAIT) && imem_rvalid && !redirect;
    id_valid  = (count != 2'd0) && !reset;
    pop       = id_valid && id_ready;
    id_instr  = fifo_instr[rd_ptr];
    id_pc     = fifo_pc[rd_ptr];
  end

  // A response in the redirect cycle still closes the transaction, so rvalid wins over DROP entry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)   state_nxt = S_IDLE;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP:  if (imem_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  wr_ptr   <= ~wr_ptr;
        if (pop)   rd_ptr   <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) req_pc <= fetch_pc;
    if (push && !reset) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table, directed corner sequences and randomized model check for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] raddr;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rpc,
                              input logic gnt, input logic rv, input logic [31:0] raddr,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_pc);
    vec_t v;
    v = '{rst, rdr, rpc, gnt, rv, raddr, rdy, e_req, e_addr, e_val, e_pc};
    return v;
  endfunction

  task automatic check(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0d: got %h expected %h", what, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk); #1;
    reset       = v.rst;
    redirect    = v.rdr;
    redirect_pc = v.rpc;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = mem_word(v.raddr);
    id_ready    = v.rdy;
    #1;
    check("imem_req", idx, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) check("imem_addr", idx, imem_addr, v.e_addr);
    check("id_valid", idx, 32'(id_valid), 32'(v.e_val));
    if (v.e_val) begin
      check("id_pc", idx, id_pc, v.e_pc);
      check("id_instr", idx, id_instr, mem_word(v.e_pc));
    end
  endtask

  vec_t        tbl[$];
  bit          mem_busy, busy, hold, after_rd;
  int          mem_cnt, accepted;
  logic [31:0] mem_addr, exp_pc, req_exp, hold_pc, hold_instr;

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;

    // rst rdr rpc      gnt rv raddr     rdy  e_req e_addr     e_val e_pc
    tbl.push_back(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0));
    tbl.push_back(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 1, 32'h0,    1,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h4,     1, 32'h0));
    tbl.push_back(mk(0, 0, 0,        0, 1, 32'h4,    1,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h8,     1, 32'h4));
    tbl.push_back(mk(0, 0, 0,        0, 1, 32'h8,    1,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        0,   1, 32'hC,     1, 32'h8));
    tbl.push_back(mk(0, 0, 0,        0, 1, 32'hC,    0,   0, 0,         1, 32'h8));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        0,   0, 0,         1, 32'h8));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   0, 0,         1, 32'h8));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h10,    1, 32'hC));
    tbl.push_back(mk(0, 1, 32'h203,  0, 1, 32'h10,   1,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h200,   0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 1, 32'h200,  1,   0, 0,         0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0,   1, 32'h204,   1, 32'h200));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1,   1, 32'h204,   1, 32'h200));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1,   1, 32'h204,   0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset during WAIT with rvalid arriving in reset, then FIFO fill with decode stalled
    apply(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0), 100);
    apply(mk(0, 0, 0,        1, 0, 0,        0,   1, 32'h0,     0, 0), 101);
    apply(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0), 102);
    apply(mk(1, 0, 0,        0, 1, 32'h0,    0,   0, 0,         0, 0), 103);
    apply(mk(0, 0, 0,        0, 1, 32'h0,    0,   1, 32'h0,     0, 0), 104);
    apply(mk(0, 0, 0,        1, 0, 0,        0,   1, 32'h0,     0, 0), 105);
    apply(mk(0, 0, 0,        0, 1, 32'h0,    0,   0, 0,         0, 0), 106);
    apply(mk(0, 0, 0,        1, 0, 0,        0,   1, 32'h4,     1, 32'h0), 107);
    apply(mk(0, 0, 0,        0, 1, 32'h4,    0,   0, 0,         1, 32'h0), 108);
    apply(mk(0, 0, 0,        1, 0, 0,        0,   0, 0,         1, 32'h0), 109);
    apply(mk(0, 0, 0,        1, 0, 0,        1,   0, 0,         1, 32'h0), 110);
    apply(mk(0, 0, 0,        0, 0, 0,        1,   1, 32'h8,     1, 32'h4), 111);
    apply(mk(0, 0, 0,        0, 0, 0,        0,   1, 32'h8,     0, 0), 112);

    // Redirect while WAIT drops the returning word; redirect with a full head; wrap at top of memory
    apply(mk(0, 0, 0,        1, 0, 0,        0,   1, 32'h8,     0, 0), 200);
    apply(mk(0, 1, 32'h100,  0, 0, 0,        0,   0, 0,         0, 0), 201);
    apply(mk(0, 0, 0,        1, 1, 32'h8,    0,   0, 0,         0, 0), 202);
    apply(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h100,   0, 0), 203);
    apply(mk(0, 0, 0,        0, 1, 32'h100,  1,   0, 0,         0, 0), 204);
    apply(mk(0, 1, 32'hFFFF_FFFE, 1, 0, 0,   0,   0, 0,         1, 32'h100), 205);
    apply(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'hFFFF_FFFC, 0, 0), 206);
    apply(mk(0, 0, 0,        0, 1, 32'hFFFF_FFFC, 1, 0, 0,      0, 0), 207);
    apply(mk(0, 0, 0,        1, 0, 0,        1,   1, 32'h0,     1, 32'hFFFF_FFFC), 208);

    // Randomized traffic against a stream-level model
    apply(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0), 300);
    apply(mk(1, 0, 0,        0, 0, 0,        0,   0, 0,         0, 0), 301);
    mem_busy = 0; hold = 0; after_rd = 0; accepted = 0;
    exp_pc = 32'h0; req_exp = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset       = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      busy        = mem_busy;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_busy    = 0;
        end
      end
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      imem_gnt    = ($urandom_range(3) != 0);
      id_ready    = ($urandom_range(2) != 0);
      #1;
      check("rnd_req_excl", c, 32'(imem_req && (busy || redirect)), 32'h0);
      if (after_rd) check("rnd_valid_after_redirect", c, 32'(id_valid), 32'h0);
      if (hold) begin
        check("rnd_hold_valid", c, 32'(id_valid), 32'h1);
        check("rnd_hold_pc", c, id_pc, hold_pc);
        check("rnd_hold_instr", c, id_instr, hold_instr);
      end
      if (id_valid && id_ready) begin
        check("rnd_id_pc", c, id_pc, exp_pc);
        check("rnd_id_instr", c, id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (imem_req && imem_gnt) begin
        check("rnd_imem_addr", c, imem_addr, req_exp);
        req_exp  = req_exp + 32'd4;
        mem_busy = 1;
        mem_cnt  = $urandom_range(3, 1);
        mem_addr = imem_addr;
      end
      hold       = id_valid && !id_ready && !redirect;
      hold_pc    = id_pc;
      hold_instr = id_instr;
      after_rd   = redirect;
      if (redirect) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        req_exp = exp_pc;
      end
    end
    nvec++;
    if (accepted < 200) begin
      nerr++;
      $display("FAIL rnd_throughput: got %0d accepted expected at least 200", accepted);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
